// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and helpers for the keypad scanner slice.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int KEY_W    = NUM_ROWS + NUM_COLS;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_t;

  localparam logic [KEY_W-1:0] KEY_NONE = '0;

  function automatic logic [3:0] count_ones(input logic [NUM_ROWS*NUM_COLS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the committed-key outputs handed to keypad_decoder.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_in;
  logic [NUM_COLS-1:0] col_out;
  logic [KEY_W-1:0]    keypad;
  logic                key_valid;
  logic                key_held;
  logic                multi_key;

  modport master (input row_in, output col_out, keypad, key_valid, key_held, multi_key);
  modport slave  (output row_in, input col_out, keypad, key_valid, key_held, multi_key);

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the raw row lines, synchronous active-low clear.
module keypad_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x3 keypad front end with frame-based debounce.
// Optional auto-repeat of key_valid when KEYPAD_AUTOREPEAT_EN is defined.
//
// state    | meaning
// RELEASED | no key committed, keypad = KEY_NONE
// PRESSED  | a key is committed and held, keypad = {row, col}
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_FRAMES   = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  bus
);

  localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [NUM_ROWS-1:0] row_s;
  logic [DW-1:0]       dwell;
  logic [1:0]          col_idx;
  logic [NUM_ROWS-1:0] cap0, cap1;
  logic                dwell_end, frame_end;

  logic [3:0]          n_contacts;
  logic [KEY_W-1:0]    code, prev_code, keypad_q;
  logic [DBW-1:0]      deb_cnt, deb_nx;
  logic                stable;

  key_state_t          state, state_nx;
  logic                commit, release_key, rep_fire;
  logic                key_valid_q, key_held_q, multi_q;

  keypad_row_sync #(.WIDTH(NUM_ROWS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.row_in),
    .q     (row_s)
  );

  assign dwell_end = (dwell == DW'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (col_idx == 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= '0;
      cap0    <= '0;
      cap1    <= '0;
    end else if (dwell_end) begin
      dwell   <= '0;
      col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
      if (col_idx == 2'd0) cap0 <= row_s;
      if (col_idx == 2'd1) cap1 <= row_s;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // Column 2 is never stored; the frame is judged on the live synchronized rows.
  assign n_contacts = count_ones({row_s, cap1, cap0});

  always_comb begin
    code = KEY_NONE;
    if (n_contacts == 4'd1) begin
      if (cap0 != '0)      code = {cap0, 3'b001};
      else if (cap1 != '0) code = {cap1, 3'b010};
      else                 code = {row_s, 3'b100};
    end
  end

  always_comb begin
    if (code == prev_code)
      deb_nx = (deb_cnt == DBW'(DEBOUNCE_FRAMES)) ? deb_cnt : deb_cnt + 1'b1;
    else
      deb_nx = DBW'(1);
  end

  assign stable = (deb_nx == DBW'(DEBOUNCE_FRAMES));

  always_comb begin
    state_nx    = state;
    commit      = 1'b0;
    release_key = 1'b0;
    case (state)
      RELEASED: begin
        if (frame_end && stable && code != KEY_NONE) begin
          commit   = 1'b1;
          state_nx = PRESSED;
        end
      end
      PRESSED: begin
        if (frame_end && stable) begin
          if (code == KEY_NONE) begin
            release_key = 1'b1;
            state_nx    = RELEASED;
          end else if (code != keypad_q) begin
            commit = 1'b1;
          end
        end
      end
      default: state_nx = RELEASED;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_cnt;

  // Counts frames spent in PRESSED since the last commit.
  assign rep_fire = frame_end && (state == PRESSED) && !commit && !release_key &&
                    (rep_cnt == RW'(REPEAT_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                    rep_cnt <= '0;
    else if (commit || release_key) rep_cnt <= '0;
    else if (frame_end && state == PRESSED)
      rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RELEASED;
      prev_code   <= KEY_NONE;
      deb_cnt     <= '0;
      multi_q     <= 1'b0;
      keypad_q    <= KEY_NONE;
      key_held_q  <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      key_valid_q <= commit | rep_fire;
      if (frame_end) begin
        prev_code <= code;
        deb_cnt   <= deb_nx;
        multi_q   <= (n_contacts > 4'd1);
      end
      if (commit) begin
        keypad_q   <= code;
        key_held_q <= 1'b1;
      end else if (release_key) begin
        keypad_q   <= KEY_NONE;
        key_held_q <= 1'b0;
      end
    end
  end

  assign bus.col_out   = NUM_COLS'(1) << col_idx;
  assign bus.keypad    = keypad_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;
  assign bus.multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed plus randomized frame-level checks of keypad_scanner against a key-matrix model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 2;
  localparam int FRAME    = 3 * SCAN_DIV;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] pat   = '0;   // pressed keys: bit = col*4 + row

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] m_key   = '0;
  logic       m_multi = 1'b0;
  int         m_rep   = 0;
  logic [6:0] hist[$];

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEB)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_FRAMES   (REP)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Passive matrix: a driven column shows its pressed rows on the row lines.
  assign bus.row_in = ({4{bus.col_out[0]}} & pat[3:0]) |
                      ({4{bus.col_out[1]}} & pat[7:4]) |
                      ({4{bus.col_out[2]}} & pat[11:8]);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input logic exp_valid, input logic [2:0] exp_col);
    chk("keypad",    8'(bus.keypad),    8'(m_key));
    chk("key_held",  8'(bus.key_held),  8'(m_key != 7'd0));
    chk("key_valid", 8'(bus.key_valid), 8'(exp_valid));
    chk("multi_key", 8'(bus.multi_key), 8'(m_multi));
    chk("col_out",   8'(bus.col_out),   8'(exp_col));
  endtask

  // Frame-level reference: classify contacts, require DEB equal frames, then commit.
  task automatic model_frame(input logic [11:0] p, output logic exp_valid);
    int n, idx;
    logic [3:0] rb;
    logic [2:0] cb;
    logic [6:0] code;
    logic stable;
    n = 0; idx = 0;
    for (int i = 0; i < 12; i++) if (p[i]) begin n++; idx = i; end
    rb = 4'b0001 << (idx % 4);
    cb = 3'b001 << (idx / 4);
    code = (n == 1) ? {rb, cb} : 7'd0;
    m_multi = (n > 1);
    hist.push_back(code);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != code) stable = 1'b0;
    exp_valid = 1'b0;
    if (stable && code != m_key) begin
      exp_valid = (code != 7'd0);
      m_key = code;
      m_rep = 0;
    end else if (m_key != 7'd0) begin
`ifdef KEYPAD_AUTOREPEAT_EN
      m_rep++;
      if (m_rep == REP) begin
        exp_valid = 1'b1;
        m_rep = 0;
      end
`endif
    end
  endtask

  task automatic run_frame(input logic [11:0] p);
    logic ev;
    pat = p;
    for (int cyc = 1; cyc <= FRAME; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      ev = 1'b0;
      if (cyc == FRAME) model_frame(p, ev);
      check_all(ev, 3'b001 << ((cyc / SCAN_DIV) % 3));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    hist.delete();
    m_key = '0; m_multi = 1'b0; m_rep = 0;
    check_all(1'b0, 3'b001);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] p;
    int sel, k1, k2;
    logic [11:0] one;
    one = 12'd1;

    do_reset();

    // clean press of row0/col0, then release
    repeat (4) run_frame(12'h001);
    repeat (3) run_frame(12'h000);

    // bounce on row1/col1, then steady
    run_frame(12'h020); run_frame(12'h000); run_frame(12'h020);
    run_frame(12'h000); run_frame(12'h020);
    repeat (3) run_frame(12'h020);
    repeat (3) run_frame(12'h000);

    // two contacts in column 0
    repeat (3) run_frame(12'h003);
    run_frame(12'h000);

    // rollover row1/col1 -> row2/col1
    repeat (3) run_frame(12'h020);
    repeat (3) run_frame(12'h040);
    repeat (3) run_frame(12'h000);

    // reset after two stable frames
    repeat (2) run_frame(12'h001);
    do_reset();
    repeat (3) run_frame(12'h001);
    repeat (3) run_frame(12'h000);

    // long hold (auto-repeat cadence when enabled)
    repeat (9) run_frame(12'h100);
    repeat (3) run_frame(12'h000);

    p = '0;
    for (int f = 0; f < 80; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 6) p = '0;
      else if (sel == 7 || sel == 8) p = one << $urandom_range(0, 11);
      else if (sel == 9) begin
        k1 = $urandom_range(0, 11);
        k2 = (k1 + 1 + $urandom_range(0, 10)) % 12;
        p = (one << k1) | (one << k2);
      end
      run_frame(p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
